secuenciador_leds: RTL
======================

# secuenciador_leds

Parametrised LED sequencer driving a one-hot walking light across `N_LEDS` outputs. It supports manual forward/backward stepping from button levels with internal edge detection, and three auto-run modes: forward, reverse and ping-pong, paced by a run-time programmable prescaler. It sits between the debounced/synchronised board inputs and the LED pins, replacing the fixed 8-LED forward-only stepper.

## Interface
Parameters:
- `N_LEDS`, 8: number of LED outputs; legal range 2..256.
- `ACTIVO_BAJO`, 1: 1 = lit LED driven 0, others 1; 0 = lit LED driven 1, others 0.
- `PER_W`, 24: width of the `periodo` input.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `avanzar`  in  1  level; a rising edge steps position +1.
- `retroceder`  in  1  level; a rising edge steps position −1.
- `reiniciar`  in  1  level; while high, holds position at 0.
- `modo`  in  2  00 manual, 01 auto forward, 10 auto reverse, 11 auto ping-pong.
- `periodo`  in  PER_W  clock cycles per auto step; 0 disables auto stepping.
- `led`  out  N_LEDS  one-hot (polarity per `ACTIVO_BAJO`) decode of position.
- `posicion`  out  max(1,$clog2(N_LEDS))  current position.
- `vuelta`  out  1  one-cycle pulse on wrap or ping-pong return to 0.

## Operation
- State: position, direction (fwd/rev), prescaler counter (PER_W bits), previous-level registers for `avanzar`/`retroceder`, registered `modo`.
- Reset values:
  - position 0; direction fwd; prescaler 0; `vuelta` 0.
  - Edge registers reset to 1, so a button held through reset does not step.
  - `led` = bit0 lit; with `ACTIVO_BAJO`=1 and N=8 this is 8'hFE.
- Per-cycle priority, highest first: `reiniciar` > manual edge > auto tick.
- `reiniciar`:
  - Forces position 0, direction fwd and prescaler 0.
  - No `vuelta` pulse.
  - Edges arriving during `reiniciar` are discarded.
- Manual edges (active in every `modo`):
  - `avanzar` edge: N−1→0 wraps and pulses `vuelta`.
  - `retroceder` edge: 0→N−1 wraps and pulses `vuelta`.
  - Both edges in the same cycle: no move, no pulse.
  - Any manual step clears the prescaler.
- Auto tick:
  - The prescaler counts 0..`periodo`−1; a tick fires when count == `periodo`−1, and the count returns to 0.
  - Mode 00 or `periodo`=0: prescaler held at 0.
  - 01: +1 with wrap; `vuelta` on N−1→0.
  - 10: −1 with wrap; `vuelta` on 0→N−1.
  - 11: ping-pong. Step in the current direction. Reaching N−1 flips direction to rev; reaching 0 flips it to fwd and pulses `vuelta`. Endpoints are not repeated; the N=4 sequence is 0,1,2,3,2,1,0,1…
- `modo` change, detected against the registered copy:
  - Prescaler cleared; position kept.
  - Entering 11: direction = rev if position == N−1, else fwd.
- Manual steps in mode 11 do not change direction, except at endpoints: landing on N−1 sets rev, landing on 0 sets fwd.
- `periodo` changed mid-count: the new value applies at the next compare. If count ≥ new `periodo`−1, a tick fires on the next cycle.

## Timing
- Input rising edge sampled in cycle k → `posicion`/`led` updated in cycle k+1 (1-cycle latency).
- `vuelta` is registered, high exactly in the cycle the new position first appears.
- `led` is a combinational decode of the position register; no added latency.
- Auto rate: one step every `periodo` cycles. Successive position changes are exactly `periodo` cycles apart, counted from reset, mode change or manual step.
- `reiniciar` asserted in cycle k → position 0 in cycle k+1, and held while asserted.

## Structure
- Package `secuenciador_leds_pkg`: `modo` encodings MODO_MANUAL, MODO_AUTO_ADEL, MODO_AUTO_ATRAS, MODO_PINGPONG; direction constants.
- Sub-module `detector_flanco`: registered rising-edge detector with reset-to-1 previous level; instantiated twice.
- The position/direction/prescaler logic lives in the top module.

## Test plan
- Reset, N=8, ACTIVO_BAJO=1: `led`=8'hFE, `posicion`=0, `vuelta`=0. Hold `avanzar` high across reset release → no step.
- Manual wrap: 8 `avanzar` pulses → positions 1..7,0; `vuelta` high one cycle on 7→0. Then one `retroceder` → position 7 with `vuelta`. Simultaneous `avanzar`+`retroceder` edges → no change.
- Auto forward, `periodo`=3: position increments every 3 cycles. `modo`=10 mid-run → prescaler restarts and the next step is −1 exactly 3 cycles later.
- Ping-pong, N=4, `periodo`=1: sequence 0,1,2,3,2,1,0,1 on consecutive cycles; `vuelta` only on arrival at 0. N=2 gives 0,1,0,1.
- `reiniciar` pulse during auto at position 5 → position 0 in the next cycle, direction fwd, no `vuelta`. Stepping resumes `periodo` cycles after release.
- `periodo`=0 in mode 01 → position frozen while manual steps still work. ACTIVO_BAJO=0 build with position 2 → `led`=8'h04.

Source files
------------

// File: rtl/secuenciador_leds_pkg.sv
// -----------------------------------------------------------------------------
// secuenciador_leds_pkg
// Shared definitions for the LED sequencer:
//   modo_t  - operating mode encodings driven on the 2-bit `modo` port
//   dir_t   - walking direction used by the ping-pong mode
//   ancho_posicion() - width of the position bus for a given LED count
// -----------------------------------------------------------------------------
package secuenciador_leds_pkg;

    typedef enum logic [1:0] {
        MODO_MANUAL     = 2'b00,
        MODO_AUTO_ADEL  = 2'b01,
        MODO_AUTO_ATRAS = 2'b10,
        MODO_PINGPONG   = 2'b11
    } modo_t;

    typedef enum logic {
        DIR_ADEL  = 1'b0,
        DIR_ATRAS = 1'b1
    } dir_t;

    // Position bus width; at least one bit even for degenerate counts.
    function automatic int ancho_posicion(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/secuenciador_leds_detector_flanco.sv
// -----------------------------------------------------------------------------
// detector_flanco
// Rising-edge detector for an already synchronised button level.
//   clk    in  clock
//   rst    in  synchronous active-high reset
//   nivel  in  button level
//   flanco out high in the cycle `nivel` is 1 and was 0 the cycle before
// The previous-level register resets to 1 so that a button held through
// reset is not seen as a press when reset is released.
// -----------------------------------------------------------------------------
module detector_flanco (
    input  logic clk,
    input  logic rst,
    input  logic nivel,
    output logic flanco
);

    logic nivel_ant;

    always_ff @(posedge clk) begin
        if (rst) begin
            nivel_ant <= 1'b1;
        end else begin
            nivel_ant <= nivel;
        end
    end

    assign flanco = nivel & ~nivel_ant;

endmodule

// File: rtl/secuenciador_leds.sv
// -----------------------------------------------------------------------------
// secuenciador_leds
// One-hot walking light over N_LEDS outputs with manual stepping and three
// auto-run modes (forward, reverse, ping-pong) paced by a programmable
// prescaler.
//   clk         in   clock, all state changes on the rising edge
//   rst         in   synchronous active-high reset
//   avanzar     in   button level, rising edge steps +1
//   retroceder  in   button level, rising edge steps -1
//   reiniciar   in   while high, position held at 0
//   modo        in   00 manual, 01 auto fwd, 10 auto rev, 11 ping-pong
//   periodo     in   clock cycles per auto step, 0 disables auto stepping
//   led         out  one-hot decode of position (active-low when ACTIVO_BAJO)
//   posicion    out  current position
//   vuelta      out  one-cycle pulse on wrap / ping-pong return to 0
// -----------------------------------------------------------------------------
module secuenciador_leds
    import secuenciador_leds_pkg::*;
#(
    parameter int N_LEDS      = 8,
    parameter int ACTIVO_BAJO = 1,
    parameter int PER_W       = 24
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 avanzar,
    input  logic                                 retroceder,
    input  logic                                 reiniciar,
    input  logic [1:0]                           modo,
    input  logic [PER_W-1:0]                     periodo,
    output logic [N_LEDS-1:0]                    led,
    output logic [ancho_posicion(N_LEDS)-1:0]    posicion,
    output logic                                 vuelta
);

    localparam int               POS_W  = ancho_posicion(N_LEDS);
    localparam logic [POS_W-1:0] ULTIMA = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] CERO   = '0;
    localparam logic [POS_W-1:0] UNO_P  = POS_W'(1);
    localparam logic [PER_W-1:0] UNO_C  = PER_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [POS_W-1:0] pos_q,    pos_d;
    dir_t             dir_q,    dir_d;
    logic [PER_W-1:0] presc_q,  presc_d;
    logic             vuelta_q, vuelta_d;
    modo_t            modo_q;

    modo_t modo_act;
    logic  flanco_av;
    logic  flanco_re;
    logic  paso_man;
    logic  cambio_modo;
    logic  ir_atras;
    logic  [N_LEDS-1:0] led_uno;

    assign modo_act = modo_t'(modo);

    // -------------------------------------------------------------------------
    // Button edge detection
    // -------------------------------------------------------------------------
    detector_flanco u_flanco_avanzar (
        .clk    (clk),
        .rst    (rst),
        .nivel  (avanzar),
        .flanco (flanco_av)
    );

    detector_flanco u_flanco_retroceder (
        .clk    (clk),
        .rst    (rst),
        .nivel  (retroceder),
        .flanco (flanco_re)
    );

    // Simultaneous forward and backward presses cancel each other and the
    // cycle is treated as having no manual event.
    assign paso_man    = flanco_av ^ flanco_re;
    assign cambio_modo = (modo_act != modo_q);

    // -------------------------------------------------------------------------
    // Wrapping step helpers
    // -------------------------------------------------------------------------
    function automatic logic [POS_W-1:0] siguiente(input logic [POS_W-1:0] p);
        return (p == ULTIMA) ? CERO : p + UNO_P;
    endfunction

    function automatic logic [POS_W-1:0] anterior(input logic [POS_W-1:0] p);
        return (p == CERO) ? ULTIMA : p - UNO_P;
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q    <= CERO;
            dir_q    <= DIR_ADEL;
            presc_q  <= '0;
            vuelta_q <= 1'b0;
            modo_q   <= MODO_MANUAL;
        end else begin
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            presc_q  <= presc_d;
            vuelta_q <= vuelta_d;
            modo_q   <= modo_act;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: reiniciar > manual edge > mode change > auto tick
    // -------------------------------------------------------------------------
    always_comb begin
        pos_d    = pos_q;
        dir_d    = dir_q;
        presc_d  = presc_q;
        vuelta_d = 1'b0;
        ir_atras = 1'b0;

        if (reiniciar) begin
            pos_d   = CERO;
            dir_d   = DIR_ADEL;
            presc_d = '0;
        end else if (paso_man) begin
            presc_d = '0;
            if (flanco_av) begin
                pos_d    = siguiente(pos_q);
                vuelta_d = (pos_q == ULTIMA);
            end else begin
                pos_d    = anterior(pos_q);
                vuelta_d = (pos_q == CERO);
            end
            // In ping-pong, direction only follows manual steps at the ends;
            // when the step coincides with entering ping-pong, the entry rule
            // is applied to the landing position.
            if (modo_act == MODO_PINGPONG) begin
                if (pos_d == ULTIMA) begin
                    dir_d = DIR_ATRAS;
                end else if (pos_d == CERO) begin
                    dir_d = DIR_ADEL;
                end else if (cambio_modo) begin
                    dir_d = DIR_ADEL;
                end
            end
        end else if (cambio_modo) begin
            presc_d = '0;
            if (modo_act == MODO_PINGPONG) begin
                dir_d = (pos_q == ULTIMA) ? DIR_ATRAS : DIR_ADEL;
            end
        end else if (modo_act == MODO_MANUAL || periodo == '0) begin
            presc_d = '0;
        end else if (presc_q >= periodo - UNO_C) begin
            // ">=" so that shortening periodo mid-count ticks right away.
            presc_d = '0;
            case (modo_act)
                MODO_AUTO_ADEL: begin
                    pos_d    = siguiente(pos_q);
                    vuelta_d = (pos_q == ULTIMA);
                end
                MODO_AUTO_ATRAS: begin
                    pos_d    = anterior(pos_q);
                    vuelta_d = (pos_q == CERO);
                end
                default: begin
                    // Ping-pong. The ends always force a turn, regardless of
                    // the stored direction, so the walk can never leave range.
                    ir_atras = (pos_q == ULTIMA) ||
                               (dir_q == DIR_ATRAS && pos_q != CERO);
                    if (ir_atras) begin
                        pos_d = pos_q - UNO_P;
                        if (pos_d == CERO) begin
                            dir_d    = DIR_ADEL;
                            vuelta_d = 1'b1;
                        end else begin
                            dir_d = DIR_ATRAS;
                        end
                    end else begin
                        pos_d = pos_q + UNO_P;
                        dir_d = (pos_d == ULTIMA) ? DIR_ATRAS : DIR_ADEL;
                    end
                end
            endcase
        end else begin
            presc_d = presc_q + UNO_C;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        led_uno = '0;
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            led_uno[i] = (pos_q == POS_W'(i));
        end
        led      = (ACTIVO_BAJO != 0) ? ~led_uno : led_uno;
        posicion = pos_q;
        vuelta   = vuelta_q;
    end

endmodule
